logic_unit_seq: RTL and testbench
=================================

Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle bitwise logic unit; successor to the fixed 32-bit combinational AND block in the ALU32 datapath.
- Accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake.
- Evaluates the operation SLICE bits per cycle, LSB slice first, into a result register.
- Presents the result plus a zero flag over an output valid/ready handshake. Sits between ALU operand registers and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH >= 1.
- SLICE, 8, bits evaluated per cycle; must divide WIDTH exactly; SLICE = WIDTH gives single-cycle evaluation.

Ports:
- Clk  input  1  sole clock, rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- In_valid  input  1  operand/opcode present.
- In_ready  output  1  unit can accept a new operation.
- Op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 In1 AND NOT In2, 7 PASS In1.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- Out_valid  output  1  result available.
- Out_ready  input  1  consumer takes result.
- Out  output  WIDTH  result register.
- Zero  output  1  high when Out == 0; valid while Out_valid is high.

Behaviour:
- One clock domain (Clk). Reset Rst_n is asynchronous and active-low.
- Reset values: state IDLE; In_ready = 1; Out_valid = 0; Out = 0; Zero = 0; slice counter = 0; operand and opcode latches = 0.
- States:
  - IDLE: In_ready = 1. On In_valid & In_ready, latch In1, In2, Op; clear counter; go to BUSY.
  - BUSY: In_ready = 0. Each cycle, compute slice[cnt] = f(Op, In1_l[cnt*SLICE +: SLICE], In2_l[...]) and write it into Out at the same position. Increment cnt. After the slice with cnt = NSLICE-1 (NSLICE = WIDTH/SLICE), go to DONE.
  - DONE: Out_valid = 1; Zero = (Out == 0). Out and Zero stay stable until the handshake. On Out_ready, go to IDLE next cycle. Out keeps its last value; Out_valid drops.
- Latency: accept edge to Out_valid high is NSLICE + 1 cycles. Throughput is one operation per NSLICE + 2 cycles.
- No bypass: In_ready does not rise in the cycle Out_ready is accepted. It rises the following cycle (IDLE).
- Input changes during BUSY or DONE are ignored; only the latched values are used.
- Out_ready while not in DONE is ignored.
- Out is not cleared at accept. Bits not yet written during BUSY hold the previous result. Consumers may sample Out only while Out_valid is high.
- All 8 opcodes are defined; there is no illegal-op path.
- SLICE = WIDTH: BUSY lasts exactly 1 cycle.
- Reset asserted mid-BUSY or in DONE: immediately (asynchronously) returns to IDLE with all reset values. The in-flight operation is discarded; no Out_valid pulse follows.
- Zero is combinational from the result register but gated by Out_valid. It is 0 whenever Out_valid is 0.

Test Plan:
- Reset, then In1=32'hF0F0_F0F0, In2=32'hFF00_FF00, Op=0 (AND), WIDTH=32, SLICE=8. Expected: In_ready low for 4 BUSY cycles; Out_valid high on cycle 5 after accept; Out=32'hF000_F000; Zero=0.
- Op sweep with In1=32'h1234_5678, In2=32'h0F0F_0F0F. Expected results:
  - OR: 32'h1F3F_5F7F
  - XOR: 32'h1D3B_5977
  - NOR: 32'hE0C0_A080
  - NAND: 32'hFDFB_F9F7
  - XNOR: 32'hE2C4_A688
  - ANDN: 32'h1030_5070
  - PASS: 32'h1234_5678
- Zero flag: In1=32'hAAAA_AAAA, In2=32'h5555_5555, Op=0. Expected: Out=0, Zero=1 while Out_valid is high; Zero=0 after the handshake.
- Backpressure: hold Out_ready=0 for 10 cycles in DONE while changing In1, In2, Op and pulsing In_valid. Expected: Out and Zero unchanged, In_ready=0. Raise Out_ready, then In_ready=1 exactly one cycle after acceptance.
- Reset mid-operation: assert Rst_n=0 for 1 cycle during the 2nd BUSY cycle. Expected: Out=0, Out_valid=0, In_ready=1 immediately, no later Out_valid. Then a fresh XOR of 32'hFFFF_FFFF with 32'h0000_FFFF gives 32'hFFFF_0000.
- Parameter corners: WIDTH=8, SLICE=8, Op=3 with In1=8'h0F, In2=8'h30 gives 8'hC0 with latency 2 cycles. WIDTH=64, SLICE=4 gives latency 17 cycles, checked against a reference model on 100 random vectors.

Source files
------------

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches two operands and an opcode, evaluates
// SLICE bits per cycle (LSB slice first) and hands the result over a valid/ready pair.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [CNT_W-1:0]               cnt;
    logic [2:0]                     op_l;
    logic [NSLICE-1:0][SLICE-1:0]   in1_l;
    logic [NSLICE-1:0][SLICE-1:0]   in2_l;
    logic [NSLICE-1:0][SLICE-1:0]   out_r;
    logic [SLICE-1:0]               slice_res;

    function automatic logic [SLICE-1:0] slice_op(
        input logic [2:0]       op,
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b
    );
        logic [SLICE-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        slice_res = slice_op(op_l, in1_l[cnt], in2_l[cnt]);
    end

    assign Out  = out_r;
    // Zero is only meaningful while a result is being offered.
    assign Zero = Out_valid & (out_r == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            In_ready  <= 1'b1;
            Out_valid <= 1'b0;
            out_r     <= '0;
            cnt       <= '0;
            in1_l     <= '0;
            in2_l     <= '0;
            op_l      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_valid) begin
                        in1_l    <= In1;
                        in2_l    <= In2;
                        op_l     <= Op;
                        cnt      <= '0;
                        In_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Unwritten slices keep the previous result until overwritten.
                    out_r[cnt] <= slice_res;
                    if (cnt == LAST) begin
                        Out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        In_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    Out_valid <= 1'b0;
                    In_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: three instances (32/8, 8/8, 64/4) checked every cycle
// against a transaction-level model, plus literal expectations from worked examples.
module tb_logic_unit_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic        iv   [3];
    logic        ordy [3];
    logic [2:0]  opa  [3];
    logic [63:0] in1a [3];
    logic [63:0] in2a [3];

    logic        irdy [3];
    logic        ov   [3];
    logic        zr   [3];
    logic [63:0] outv [3];

    logic irdy0, irdy1, irdy2, ov0, ov1, ov2, z0, z1, z2;
    logic [31:0] out0;
    logic [7:0]  out1;
    logic [63:0] out2;

    logic [31:0] in1_0, in2_0;
    logic [7:0]  in1_1, in2_1;
    logic [63:0] in1_2, in2_2;
    assign in1_0 = in1a[0][31:0];
    assign in2_0 = in2a[0][31:0];
    assign in1_1 = in1a[1][7:0];
    assign in2_1 = in2a[1][7:0];
    assign in1_2 = in1a[2];
    assign in2_2 = in2a[2];

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv[0]), .In_ready(irdy0), .Op(opa[0]),
        .In1(in1_0), .In2(in2_0), .Out_valid(ov0), .Out_ready(ordy[0]), .Out(out0), .Zero(z0));
    logic_unit_seq #(.WIDTH(8), .SLICE(8)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv[1]), .In_ready(irdy1), .Op(opa[1]),
        .In1(in1_1), .In2(in2_1), .Out_valid(ov1), .Out_ready(ordy[1]), .Out(out1), .Zero(z1));
    logic_unit_seq #(.WIDTH(64), .SLICE(4)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .In_valid(iv[2]), .In_ready(irdy2), .Op(opa[2]),
        .In1(in1_2), .In2(in2_2), .Out_valid(ov2), .Out_ready(ordy[2]), .Out(out2), .Zero(z2));

    assign irdy[0] = irdy0;
    assign irdy[1] = irdy1;
    assign irdy[2] = irdy2;
    assign ov[0]   = ov0;
    assign ov[1]   = ov1;
    assign ov[2]   = ov2;
    assign zr[0]   = z0;
    assign zr[1]   = z1;
    assign zr[2]   = z2;
    assign outv[0] = {32'd0, out0};
    assign outv[1] = {56'd0, out1};
    assign outv[2] = out2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nsl(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 16;
    endfunction

    function automatic logic [63:0] ref_f(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int k);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (k == 0) ? 64'h0000_0000_FFFF_FFFF : (k == 1) ? 64'h0000_0000_0000_00FF : '1;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a & ~b;
            default: r = a;
        endcase
        return r & mask;
    endfunction

    // Transaction model: one outstanding op per instance, result due NSLICE edges after accept.
    bit          m_pend [3];
    int          m_cnt  [3];
    logic [63:0] m_exp  [3];
    logic [63:0] m_last [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_pend[k] <= 1'b0;
                m_cnt[k]  <= 0;
                m_exp[k]  <= '0;
                m_last[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_pend[k]) begin
                    if (iv[k]) begin
                        m_pend[k] <= 1'b1;
                        m_cnt[k]  <= 0;
                        m_exp[k]  <= ref_f(opa[k], in1a[k], in2a[k], k);
                    end
                end else if (m_cnt[k] >= nsl(k)) begin
                    if (ordy[k]) begin
                        m_pend[k] <= 1'b0;
                        m_last[k] <= m_exp[k];
                    end
                end else begin
                    m_cnt[k] <= m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            automatic bit vexp = m_pend[k] && (m_cnt[k] >= nsl(k));
            chk($sformatf("in_ready[%0d]", k), {63'd0, irdy[k]}, {63'd0, !m_pend[k]});
            chk($sformatf("out_valid[%0d]", k), {63'd0, ov[k]}, {63'd0, vexp});
            chk($sformatf("zero[%0d]", k), {63'd0, zr[k]}, {63'd0, vexp && (m_exp[k] == '0)});
            if (vexp)
                chk($sformatf("out[%0d]", k), outv[k], m_exp[k]);
            else if (!m_pend[k])
                chk($sformatf("out_hold[%0d]", k), outv[k], m_last[k]);
        end
    end

    task automatic accept(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op);
        chk("ready_before_accept", {63'd0, irdy[k]}, 64'd1);
        in1a[k] = a;
        in2a[k] = b;
        opa[k]  = op;
        iv[k]   = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!ov[k] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ov[k]) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake(input int k);
        ordy[k] = 1'b1;
        chk("ready_during_hs", {63'd0, irdy[k]}, 64'd0);
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        chk("ready_after_hs", {63'd0, irdy[k]}, 64'd1);
    endtask

    logic [31:0] sweep_exp [8];
    int lat;
    logic [63:0] hold_out;
    logic hold_z;

    initial begin
        sweep_exp = '{32'h0204_0608, 32'h1F3F_5F7F, 32'h1D3B_5977, 32'hE0C0_A080,
                      32'hFDFB_F9F7, 32'hE2C4_A688, 32'h1030_5070, 32'h1234_5678};
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; opa[k] = '0; in1a[k] = '0; in2a[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", {63'd0, irdy[k]}, 64'd1);
            chk("rst_out_valid", {63'd0, ov[k]}, 64'd0);
            chk("rst_out", outv[k], 64'd0);
            chk("rst_zero", {63'd0, zr[k]}, 64'd0);
        end

        accept(0, 64'hF0F0_F0F0, 64'hFF00_FF00, 3'd0);
        wait_valid(0, lat);
        chk("and_latency", 64'(lat), 64'd5);
        chk("and_out", outv[0], 64'hF000_F000);
        chk("and_zero", {63'd0, zr[0]}, 64'd0);
        handshake(0);

        for (int op = 0; op < 8; op++) begin
            accept(0, 64'h1234_5678, 64'h0F0F_0F0F, 3'(op));
            wait_valid(0, lat);
            chk($sformatf("sweep_op%0d", op), outv[0], {32'd0, sweep_exp[op]});
            handshake(0);
        end

        accept(0, 64'hAAAA_AAAA, 64'h5555_5555, 3'd0);
        wait_valid(0, lat);
        chk("zero_out", outv[0], 64'd0);
        chk("zero_flag", {63'd0, zr[0]}, 64'd1);
        handshake(0);
        chk("zero_after_hs", {63'd0, zr[0]}, 64'd0);

        accept(0, 64'h0000_00FF, 64'h0000_0F0F, 3'd2);
        wait_valid(0, lat);
        hold_out = outv[0];
        hold_z   = zr[0];
        chk("bp_out", hold_out, 64'h0000_0FF0);
        repeat (10) begin
            in1a[0] = {32'd0, $urandom};
            in2a[0] = {32'd0, $urandom};
            opa[0]  = 3'($urandom_range(0, 7));
            iv[0]   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("bp_out_stable", outv[0], hold_out);
            chk("bp_zero_stable", {63'd0, zr[0]}, {63'd0, hold_z});
            chk("bp_in_ready", {63'd0, irdy[0]}, 64'd0);
        end
        iv[0] = 1'b0;
        handshake(0);

        accept(0, 64'h1357_9BDF, 64'h2468_ACE0, 3'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", outv[0], 64'd0);
        chk("rst_mid_valid", {63'd0, ov[0]}, 64'd0);
        chk("rst_mid_ready", {63'd0, irdy[0]}, 64'd1);
        #9;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("no_valid_after_rst", {63'd0, ov[0]}, 64'd0);
        end
        accept(0, 64'hFFFF_FFFF, 64'h0000_FFFF, 3'd2);
        wait_valid(0, lat);
        chk("xor_after_rst", outv[0], 64'hFFFF_0000);
        handshake(0);

        accept(1, 64'h0F, 64'h30, 3'd3);
        wait_valid(1, lat);
        chk("w8_latency", 64'(lat), 64'd2);
        chk("w8_nor", outv[1], 64'hC0);
        handshake(1);

        for (int i = 0; i < 100; i++) begin
            accept(2, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            wait_valid(2, lat);
            chk("w64_latency", 64'(lat), 64'd17);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            handshake(2);
        end

        for (int i = 0; i < 30; i++) begin
            accept(0, {32'd0, $urandom}, {32'd0, $urandom}, 3'($urandom_range(0, 7)));
            wait_valid(0, lat);
            handshake(0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
